// File: rtl/dr_counter_sync.sv
// dr_counter_sync: clocked dual-rail counter source.
// Presents count_q as NCL wavefronts (DATA, NULL, DATA, ...) under a
// four-phase completeness handshake driven by sum_ack.
module dr_counter_sync #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int RST_VAL = 0
) (
  input  logic               clk,
  input  logic               init,
  input  logic               en,
  input  logic               mode_down,
  input  logic               sat,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [2*WIDTH-1:0] sum_dr,
  output logic [1:0]         carry_dr,
  input  logic               sum_ack,
  output logic [WIDTH-1:0]   count_q
);

  localparam logic [0:0] S_NULL = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_X  = WIDTH'(RST_VAL);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   count_d;
  logic [2*WIDTH-1:0] sum_q, sum_d;
  logic [1:0]         carry_q, carry_d;

  // One extra bit exposes the carry out of the add and the borrow of the subtract
  logic [WIDTH:0]     up_ext;
  logic [WIDTH:0]     dn_ext;
  logic               limit_hit;
  logic [WIDTH-1:0]   count_adv;
  logic [2*WIDTH-1:0] count_enc;

  // Dual-rail encoding of the current count: rail 1 carries the bit, rail 0 its complement
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
    assign count_enc[2*gi+1] = count_q[gi];
    assign count_enc[2*gi]   = ~count_q[gi];
  end

  // Advance value and terminal-count detection for the current direction/mode
  always_comb begin
    up_ext    = {1'b0, count_q} + STEP_X;
    dn_ext    = {1'b0, count_q} - STEP_X;
    limit_hit = mode_down ? dn_ext[WIDTH] : up_ext[WIDTH];
    if (mode_down) begin
      count_adv = (sat && limit_hit) ? '0 : dn_ext[WIDTH-1:0];
    end else begin
      count_adv = (sat && limit_hit) ? {WIDTH{1'b1}} : up_ext[WIDTH-1:0];
    end
  end

  // Handshake FSM: load or launch from NULL, return to NULL and advance on ack
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (state_q == S_NULL) begin
      if (load) begin
        count_d = load_val;
      end else if (en && !sum_ack) begin
        state_d = S_DATA;
        sum_d   = count_enc;
        carry_d = limit_hit ? 2'b10 : 2'b01;
      end
    end else begin
      if (sum_ack) begin
        state_d = S_NULL;
        sum_d   = '0;
        carry_d = 2'b00;
        count_d = count_adv;
      end
    end
  end

  // State and output registers; init overrides everything, including mid-DATA
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_NULL;
      count_q <= RST_X;
      sum_q   <= '0;
      carry_q <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_dr   = sum_q;
  assign carry_dr = carry_q;

endmodule

// File: tb/tb_dr_counter_sync.sv
// Directed bench for dr_counter_sync: two 4-bit instances, STEP=1/RST_VAL=0
// and STEP=3/RST_VAL=6, each exercised by its own scenario tasks.
module tb_dr_counter_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=4, STEP=1, RST_VAL=0
  logic       init_a, en_a, down_a, sat_a, load_a, ack_a;
  logic [3:0] lval_a, cnt_a;
  logic [7:0] sum_a;
  logic [1:0] car_a;

  // Instance B: WIDTH=4, STEP=3, RST_VAL=6
  logic       init_b, en_b, down_b, sat_b, load_b, ack_b;
  logic [3:0] lval_b, cnt_b;
  logic [7:0] sum_b;
  logic [1:0] car_b;

  dr_counter_sync #(.WIDTH(4), .STEP(1), .RST_VAL(0)) dut_a (
    .clk(clk), .init(init_a), .en(en_a), .mode_down(down_a), .sat(sat_a),
    .load(load_a), .load_val(lval_a), .sum_dr(sum_a), .carry_dr(car_a),
    .sum_ack(ack_a), .count_q(cnt_a)
  );

  dr_counter_sync #(.WIDTH(4), .STEP(3), .RST_VAL(6)) dut_b (
    .clk(clk), .init(init_b), .en(en_b), .mode_down(down_b), .sat(sat_b),
    .load(load_b), .load_val(lval_b), .sum_dr(sum_b), .carry_dr(car_b),
    .sum_ack(ack_b), .count_q(cnt_b)
  );

  // Expected dual-rail code of a 4-bit value
  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  // Advance one rising edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    init_a = 1; init_b = 1;
    repeat (3) tick();
    checks++;
    if (sum_a !== 8'h00 || car_a !== 2'b00 || cnt_a !== 4'd0) begin
      errors++;
      $display("FAIL reset_a sum=%h carry=%b count=%0d want 00/00/0", sum_a, car_a, cnt_a);
    end
    checks++;
    if (sum_b !== 8'h00 || car_b !== 2'b00 || cnt_b !== 4'd6) begin
      errors++;
      $display("FAIL reset_b sum=%h carry=%b count=%0d want 00/00/6", sum_b, car_b, cnt_b);
    end
    init_a = 0; init_b = 0;
  endtask

  // Full up-count sweep 0..15,0 with NULL between every pair of wavefronts
  task automatic test_basic_sweep();
    logic [3:0] v;
    en_a = 1; ack_a = 0;
    for (int i = 0; i <= 16; i++) begin
      v = 4'(i);
      tick();
      $display("wavefront A sum=%h carry=%b count=%0d", sum_a, car_a, cnt_a);
      checks++;
      if (sum_a !== enc4(v) || car_a !== ((v == 4'd15) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL sweep_data i=%0d sum=%h carry=%b want %h/%b", i, sum_a, car_a,
                 enc4(v), (v == 4'd15) ? 2'b10 : 2'b01);
      end
      ack_a = 1;
      tick();
      checks++;
      if (sum_a !== 8'h00 || car_a !== 2'b00 || cnt_a !== v + 4'd1) begin
        errors++;
        $display("FAIL sweep_null i=%0d sum=%h carry=%b count=%0d want 00/00/%0d", i, sum_a,
                 car_a, cnt_a, v + 4'd1);
      end
      ack_a = 0;
    end
    en_a = 0;
    tick();
  endtask

  // Run a sequence of wavefronts on instance B and compare values and carries
  task automatic run_b(input string name, input logic [3:0] exp_v[5],
                       input logic [1:0] exp_c[5], input int n);
    en_b = 1; ack_b = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      $display("wavefront B %s sum=%h carry=%b count=%0d", name, sum_b, car_b, cnt_b);
      checks++;
      if (sum_b !== enc4(exp_v[i]) || car_b !== exp_c[i]) begin
        errors++;
        $display("FAIL %s_%0d sum=%h carry=%b want %h/%b", name, i, sum_b, car_b,
                 enc4(exp_v[i]), exp_c[i]);
      end
      ack_b = 1;
      tick();
      ack_b = 0;
    end
    en_b = 0;
  endtask

  task automatic load_b_val(input logic [3:0] v);
    load_b = 1; lval_b = v;
    tick();
    load_b = 0;
  endtask

  task automatic test_down_sat();
    logic [3:0] ev[5];
    logic [1:0] ec[5];
    ev = '{4'd5, 4'd2, 4'd0, 4'd0, 4'd0};
    ec = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    down_b = 1; sat_b = 1;
    load_b_val(4'd5);
    run_b("down_sat", ev, ec, 5);
  endtask

  task automatic test_up_wrap();
    logic [3:0] ev[5];
    logic [1:0] ec[5];
    ev = '{4'd14, 4'd1, 4'd4, 4'd0, 4'd0};
    ec = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
    down_b = 0; sat_b = 0;
    load_b_val(4'd14);
    run_b("up_wrap", ev, ec, 3);
    checks++;
    if (cnt_b !== 4'd7) begin
      errors++;
      $display("FAIL up_wrap_final count=%0d want 7", cnt_b);
    end
  endtask

  task automatic test_stall();
    load_a = 1; lval_a = 4'd3; en_a = 0; ack_a = 0;
    tick();
    load_a = 0;
    // en=0 in NULL holds off DATA
    tick();
    checks++;
    if (sum_a !== 8'h00) begin
      errors++;
      $display("FAIL stall_en0 sum=%h want 00", sum_a);
    end
    en_a = 1;
    tick();
    en_a = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sum_a !== enc4(4'd3) || car_a !== 2'b01 || cnt_a !== 4'd3) begin
        errors++;
        $display("FAIL stall_hold_%0d sum=%h carry=%b count=%0d want %h/01/3", i, sum_a,
                 car_a, cnt_a, enc4(4'd3));
      end
    end
    ack_a = 1;
    tick();
    checks++;
    if (sum_a !== 8'h00 || cnt_a !== 4'd4) begin
      errors++;
      $display("FAIL stall_release sum=%h count=%0d want 00/4", sum_a, cnt_a);
    end
    en_a = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (sum_a !== 8'h00 || cnt_a !== 4'd4) begin
        errors++;
        $display("FAIL stall_ack_high_%0d sum=%h count=%0d want 00/4", i, sum_a, cnt_a);
      end
    end
    ack_a = 0;
    tick();
    checks++;
    if (sum_a !== enc4(4'd4)) begin
      errors++;
      $display("FAIL stall_resume sum=%h want %h", sum_a, enc4(4'd4));
    end
    en_a = 0; ack_a = 1;
    tick();
    ack_a = 0;
  endtask

  task automatic test_load_priority();
    load_a = 1; lval_a = 4'd9; en_a = 1; ack_a = 0;
    tick();
    load_a = 0;
    checks++;
    if (sum_a !== 8'h00 || cnt_a !== 4'd9) begin
      errors++;
      $display("FAIL load_prio sum=%h count=%0d want 00/9", sum_a, cnt_a);
    end
    tick();
    checks++;
    if (sum_a !== enc4(4'd9)) begin
      errors++;
      $display("FAIL load_data sum=%h want %h", sum_a, enc4(4'd9));
    end
    load_a = 1; lval_a = 4'd3;
    tick();
    load_a = 0;
    checks++;
    if (sum_a !== enc4(4'd9) || cnt_a !== 4'd9) begin
      errors++;
      $display("FAIL load_in_data sum=%h count=%0d want %h/9", sum_a, cnt_a, enc4(4'd9));
    end
    en_a = 0; ack_a = 1;
    tick();
    ack_a = 0;
    checks++;
    if (sum_a !== 8'h00 || cnt_a !== 4'd10) begin
      errors++;
      $display("FAIL load_advance sum=%h count=%0d want 00/10", sum_a, cnt_a);
    end
  endtask

  task automatic test_mid_reset();
    down_b = 0; sat_b = 0;
    load_b_val(4'd7);
    en_b = 1; ack_b = 0;
    tick();
    checks++;
    if (sum_b !== enc4(4'd7)) begin
      errors++;
      $display("FAIL midrst_data sum=%h want %h", sum_b, enc4(4'd7));
    end
    init_b = 1; ack_b = 1;
    tick();
    init_b = 0; ack_b = 0;
    checks++;
    if (sum_b !== 8'h00 || car_b !== 2'b00 || cnt_b !== 4'd6) begin
      errors++;
      $display("FAIL midrst_null sum=%h carry=%b count=%0d want 00/00/6", sum_b, car_b, cnt_b);
    end
    tick();
    checks++;
    if (sum_b !== enc4(4'd6) || car_b !== 2'b01) begin
      errors++;
      $display("FAIL midrst_first sum=%h carry=%b want %h/01", sum_b, car_b, enc4(4'd6));
    end
    en_b = 0;
  endtask

  initial begin
    init_a = 1; en_a = 0; down_a = 0; sat_a = 0; load_a = 0; lval_a = 0; ack_a = 0;
    init_b = 1; en_b = 0; down_b = 0; sat_b = 0; load_b = 0; lval_b = 0; ack_b = 0;
    #2;
    test_reset();
    test_basic_sweep();
    test_down_sat();
    test_up_wrap();
    test_stall();
    test_load_priority();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dr_counter_sync.md
# dr_counter_sync

Clocked, parametrised dual-rail counter source for the NCL sandbox. It emits the count as NCL wavefronts (DATA, NULL, DATA, ...) under a four-phase completeness handshake, so clocked harnesses can drive NCL pipelines and checkers. It generalises the fixed 32-digit two-D counter in four ways: width, step size, up/down mode and wrap/saturate mode. It also adds parallel load and a terminal-count carry rail.

## Interface
- WIDTH, 32: counter width in bits; the number of dual-rail digits.
- STEP, 1: increment/decrement magnitude, 1..2^WIDTH-1.
- RST_VAL, 0: count value loaded on reset.
- clk  in  1  clock; all state changes on the rising edge.
- init  in  1  reset, synchronous, active-high.
- en  in  1  permits the next DATA wavefront.
- mode_down  in  1  0 = count up, 1 = count down; sampled at the advance edge.
- sat  in  1  0 = wrap modulo 2^WIDTH, 1 = clamp at the limit; sampled at the advance edge.
- load  in  1  parallel load request; honoured only in S_NULL.
- load_val  in  WIDTH  value to load.
- sum_dr  out  2*WIDTH  dual-rail count. Digit k is {sum_dr[2k+1], sum_dr[2k]}: 10 = DATA1, 01 = DATA0, 00 = NULL.
- carry_dr  out  2  dual-rail terminal-count flag, same encoding as sum_dr.
- sum_ack  in  1  consumer completeness. 1 = DATA received, request NULL. 0 = NULL received, request DATA.
- count_q  out  WIDTH  binary count register, for debug and scoreboard.

## Operation
- State machine with two states.
  - S_NULL: sum_dr and carry_dr are all zero.
  - S_DATA: every digit of sum_dr and carry_dr is a valid DATA code.
- S_NULL → S_DATA when init=0, load=0, en=1 and sum_ack=0. The wavefront encodes count_q as it stands.
- S_DATA → S_NULL when sum_ack=1. On the same edge count_q advances by STEP.
- All other combinations hold state, outputs and count_q.
- Advance arithmetic, up, sat=0: count_q + STEP mod 2^WIDTH.
- Advance arithmetic, up, sat=1: if count_q + STEP > 2^WIDTH-1, the result is 2^WIDTH-1.
- Advance arithmetic, down, sat=0: count_q - STEP mod 2^WIDTH.
- Advance arithmetic, down, sat=1: if count_q < STEP, the result is 0.
- The sum is computed at WIDTH+1 bits internally so overflow is detected.
- carry_dr in DATA:
  - DATA1 if the next advance would wrap or clamp: up when count_q + STEP > 2^WIDTH-1, down when count_q < STEP.
  - DATA0 otherwise.
  - Evaluated with the mode_down value present at the NULL→DATA edge.
- Load: in S_NULL with load=1, count_q <= load_val and the state stays S_NULL. Load has priority over en/sum_ack that cycle. In S_DATA, load is ignored.
- No output may ever show a mixed DATA/NULL wavefront or the illegal code 11. All output bits are registered.
- init=1 at any edge:
  - state goes to S_NULL, count_q = RST_VAL, sum_dr = 0, carry_dr = 00;
  - takes effect even mid-DATA;
  - no advance occurs on that edge.

## Timing
- Reset values: sum_dr = 0, carry_dr = 00, count_q = RST_VAL, state S_NULL.
- Request to DATA: 1 cycle. The edge that samples sum_ack=0 (with en=1) drives DATA on that edge.
- Ack to NULL: 1 cycle. The edge that samples sum_ack=1 in S_DATA drives NULL and updates count_q.
- Maximum throughput: one DATA wavefront per 2 cycles when sum_ack tracks outputs combinationally. Otherwise the rate is set by the consumer.
- en=0 stalls only in S_NULL. A DATA wavefront already presented is held until acked regardless of en.
- sum_ack is sampled only at rising edges; glitches between edges are ignored.
- sum_ack=1 while in S_NULL is legal (consumer not yet NULL); the block waits.
- Load takes effect at its edge. The next wavefront (earliest the following edge) shows load_val.

## Test plan
- Reset/basic, WIDTH=4, STEP=1, RST_VAL=0:
  - hold init 3 cycles → sum_dr=0, count_q=0;
  - release with en=1 and sum_ack tied to the completion of sum_dr → wavefronts show 0,1,2,…,15,0;
  - carry_dr is DATA1 only on value 15;
  - NULL appears between every pair of DATA wavefronts.
- Down + saturate, WIDTH=4, STEP=3, load 5, mode_down=1, sat=1 → wavefronts 5, 2, 0, 0, 0; carry_dr is DATA1 on 2 and on every 0.
- Up + wrap, STEP=3, load 14 → wavefronts 14, 1, 4; carry DATA1 on 14 only.
- Handshake stall:
  - hold sum_ack=0 for 5 cycles after DATA → DATA held stable, count_q unchanged;
  - raise sum_ack → NULL and advance next edge;
  - hold sum_ack=1 4 cycles in S_NULL → no new DATA.
- Load priority: in S_NULL assert load=1 (load_val=9), en=1, sum_ack=0 on the same edge → no wavefront that edge, count_q=9, next edge DATA 9. Load asserted in S_DATA → ignored.
- Mid-operation reset: assert init while DATA 7 is presented → next edge all NULL, count_q=RST_VAL. After release, the first wavefront shows RST_VAL.
